// File: rtl/flappy_scene_render.sv
`timescale 1ns/1ps
// flappy_scene_render: 640x480@60 VGA renderer for the flappy game-state words.
// Optional macro SCORE_BAR_EN draws a 16-bit binary score bar at the top of the screen.
module flappy_scene_render #(
  parameter int DIV     = 4,
  parameter int BIRD_X  = 40,
  parameter int BIRD_SZ = 16,
  parameter int PIPE_W  = 50,
  parameter int COIN_SZ = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [15:0] score,
  input  logic [15:0] bird_y,
  input  logic [31:0] pipe1,
  input  logic [31:0] pipe2,
  input  logic [31:0] pipe3,
  input  logic [31:0] coin,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL  = 800;
  localparam int H_ACT    = 640;
  localparam int HS_BEG   = 656;
  localparam int HS_END   = 751;
  localparam int V_TOTAL  = 525;
  localparam int V_ACT    = 480;
  localparam int VS_BEG   = 490;
  localparam int VS_END   = 491;
  localparam int GROUND_Y = 464;
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]      div_q, div_d;
  logic [9:0]         h_q, h_d, v_q, v_d;
  logic               pix_en, snap;
  logic [10:0]        h11, v11;

  // Shadow copies hold only the fields the renderer actually decodes.
  logic [1:0]         status_q, status_d;
  logic [10:0]        bird_q, bird_d;
  logic [2:0][27:0]   pipe_q, pipe_d;
  logic [20:0]        coin_q, coin_d;

  logic               s1_bird_q, s1_bird_d, s1_coin_q, s1_coin_d;
  logic               s1_pipe_q, s1_pipe_d, s1_ground_q, s1_ground_d;
  logic               s1_active_q, s1_active_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic               s1_rise_q, s1_rise_d, s1_two_q, s1_two_d;

  logic               hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
  logic [11:0]        rgb_q, rgb_d, colour;

  logic [10:0]        by, cx, cy;
  logic               bird_hit, coin_hit, pipe_hit_any;
  logic               unused_bits;

`ifdef SCORE_BAR_EN
  logic [15:0]        score_q, score_d;
  logic               s1_bar_q, s1_bar_d, s1_bar_on_q, s1_bar_on_d;
  logic [10:0]        bar_off;
  logic               bar_hit, bar_on;

  assign unused_bits = ^{pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20], bird_y[14:10]};
`else
  assign unused_bits = ^{pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20], bird_y[14:10],
                         score};
`endif

  function automatic logic pipe_hit(input logic [27:0] p, input logic [10:0] h,
                                    input logic [10:0] v);
    logic [10:0] px, py, gap;
    px  = {1'b0, p[19:10]};
    py  = {1'b0, p[9:0]};
    gap = {3'b000, p[27:20]};
    return (h >= px) && (h < px + 11'(PIPE_W)) && ((v < py) || (v >= py + gap));
  endfunction

  always_comb begin
    pix_en = (div_q == DW'(DIV - 1));
    div_d  = pix_en ? '0 : div_q + 1'b1;

    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // The snapshot lands in vertical blanking so a frame never mixes two game states.
    snap          = pix_en && (h_q == 10'd0) && (v_q == 10'(V_ACT));
    frame_start_d = snap;
    status_d      = snap ? status : status_q;
    bird_d        = snap ? {bird_y[15], bird_y[9:0]} : bird_q;
    pipe_d[0]     = snap ? pipe1[27:0] : pipe_q[0];
    pipe_d[1]     = snap ? pipe2[27:0] : pipe_q[1];
    pipe_d[2]     = snap ? pipe3[27:0] : pipe_q[2];
    coin_d        = snap ? {coin[31], coin[19:0]} : coin_q;

    h11 = {1'b0, h_q};
    v11 = {1'b0, v_q};
    by  = {1'b0, bird_q[9:0]};
    cx  = {1'b0, coin_q[9:0]};
    cy  = {1'b0, coin_q[19:10]};

    bird_hit = (h11 >= 11'(BIRD_X)) && (h11 < 11'(BIRD_X + BIRD_SZ)) &&
               (v11 >= by) && (v11 < by + 11'(BIRD_SZ));
    coin_hit = coin_q[20] && (h11 >= cx) && (h11 < cx + 11'(COIN_SZ)) &&
               (v11 >= cy) && (v11 < cy + 11'(COIN_SZ));
    pipe_hit_any = pipe_hit(pipe_q[0], h11, v11) || pipe_hit(pipe_q[1], h11, v11) ||
                   pipe_hit(pipe_q[2], h11, v11);

    s1_bird_d   = pix_en ? bird_hit : s1_bird_q;
    s1_coin_d   = pix_en ? coin_hit : s1_coin_q;
    s1_pipe_d   = pix_en ? pipe_hit_any : s1_pipe_q;
    s1_ground_d = pix_en ? (v11 >= 11'(GROUND_Y)) : s1_ground_q;
    s1_active_d = pix_en ? ((h11 < 11'(H_ACT)) && (v11 < 11'(V_ACT))) : s1_active_q;
    s1_hs_d     = pix_en ? !((h11 >= 11'(HS_BEG)) && (h11 <= 11'(HS_END))) : s1_hs_q;
    s1_vs_d     = pix_en ? !((v11 >= 11'(VS_BEG)) && (v11 <= 11'(VS_END))) : s1_vs_q;
    s1_rise_d   = pix_en ? bird_q[10] : s1_rise_q;
    s1_two_d    = pix_en ? (status_q == 2'b11) : s1_two_q;

`ifdef SCORE_BAR_EN
    score_d     = snap ? score : score_q;
    bar_off     = h11 - 11'd200;
    bar_hit     = (v11 >= 11'd4) && (v11 <= 11'd11) && (h11 >= 11'd200) &&
                  (h11 < 11'd456) && (bar_off[3:0] < 4'd12);
    bar_on      = score_q[4'd15 - bar_off[7:4]];
    s1_bar_d    = pix_en ? bar_hit : s1_bar_q;
    s1_bar_on_d = pix_en ? bar_on : s1_bar_on_q;
`endif

    colour = 12'h6CF;
    if (!s1_active_q)   colour = 12'h000;
    else if (s1_bird_q) colour = s1_rise_q ? 12'hFA0 : 12'hFF0;
    else if (s1_coin_q) colour = 12'hFD0;
`ifdef SCORE_BAR_EN
    else if (s1_bar_q)  colour = s1_bar_on_q ? 12'hFFF : 12'h333;
`endif
    else if (s1_pipe_q) colour = s1_two_q ? 12'h06C : 12'h0A0;
    else if (s1_ground_q) colour = 12'h864;

    rgb_d   = pix_en ? colour : rgb_q;
    hsync_d = pix_en ? s1_hs_q : hsync_q;
    vsync_d = pix_en ? s1_vs_q : vsync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      status_q      <= '0;
      bird_q        <= '0;
      pipe_q        <= '0;
      coin_q        <= '0;
      s1_bird_q     <= 1'b0;
      s1_coin_q     <= 1'b0;
      s1_pipe_q     <= 1'b0;
      s1_ground_q   <= 1'b0;
      s1_active_q   <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_rise_q     <= 1'b0;
      s1_two_q      <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef SCORE_BAR_EN
      score_q       <= '0;
      s1_bar_q      <= 1'b0;
      s1_bar_on_q   <= 1'b0;
`endif
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      status_q      <= status_d;
      bird_q        <= bird_d;
      pipe_q        <= pipe_d;
      coin_q        <= coin_d;
      s1_bird_q     <= s1_bird_d;
      s1_coin_q     <= s1_coin_d;
      s1_pipe_q     <= s1_pipe_d;
      s1_ground_q   <= s1_ground_d;
      s1_active_q   <= s1_active_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_rise_q     <= s1_rise_d;
      s1_two_q      <= s1_two_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef SCORE_BAR_EN
      score_q       <= score_d;
      s1_bar_q      <= s1_bar_d;
      s1_bar_on_q   <= s1_bar_on_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule
